// File: rtl/datapath_mc.sv
// Multicycle RV32I-subset datapath sharing one memory port: 3 (branch) / 4 (ALU, jump, store) / 5 (load) cycles.
// Each mem_ready-low cycle in FETCH/MEM adds one cycle; the request is held stable and never withdrawn.
package datapath_mc_pkg;
    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} instr_type_e;
endpackage

module datapath_mc
    import datapath_mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  instr_type_e     instr_type_enum_inst,
    input  logic [3:0]      ALUControl,
    input  logic            ALUSrc,
    input  logic [1:0]      ResultSrc,
    input  logic            write_enable_rd,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_branch,
    input  logic            branch_invert,
    input  logic            is_jump,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [2:0]      state,
    output logic            instr_done
);
    localparam int RW  = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
    } state_e;

    state_e            r_state, w_state_nxt;
    logic              r_active;
    logic [XLEN-1:0]   r_pc, r_old_pc, r_a, r_b, r_alu_out, r_mem_data;
    logic [31:0]       r_instr;
    logic [XLEN-1:0]   r_rf [NREGS];

    logic [RW-1:0]     w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]   w_rs1_val, w_rs2_val;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm_ext, w_src_b, w_alu, w_result;
    logic [SHW-1:0]    w_shamt;
    logic              w_zero, w_taken, w_xfer, w_in_mem;

    assign w_rs1     = r_instr[15 +: RW];
    assign w_rs2     = r_instr[20 +: RW];
    assign w_rd      = r_instr[7 +: RW];
    assign w_rs1_val = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == '0) ? '0 : r_rf[w_rs2];

    always_comb begin
        w_imm32 = '0;
        case (instr_type_enum_inst)
            IMM_I:   w_imm32 = {{20{r_instr[31]}}, r_instr[31:20]};
            IMM_S:   w_imm32 = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
            IMM_B:   w_imm32 = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                                r_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {r_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                                r_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end
    assign w_imm_ext = XLEN'($signed(w_imm32));

    assign w_src_b = ALUSrc ? w_imm_ext : r_b;
    assign w_shamt = w_src_b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (ALUControl)
            4'd0:    w_alu = r_a + w_src_b;
            4'd1:    w_alu = r_a - w_src_b;
            4'd2:    w_alu = r_a & w_src_b;
            4'd3:    w_alu = r_a | w_src_b;
            4'd4:    w_alu = r_a ^ w_src_b;
            4'd5:    w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_src_b))};
            4'd6:    w_alu = r_a << w_shamt;
            4'd7:    w_alu = r_a >> w_shamt;
            default: w_alu = '0;
        endcase
    end
    assign w_zero  = (w_alu == '0);
    assign w_taken = w_zero ^ branch_invert;

    always_comb begin
        w_result = '0;
        case (ResultSrc)
            2'd0:    w_result = r_alu_out;
            2'd1:    w_result = r_mem_data;
            2'd2:    w_result = r_old_pc + XLEN'(4);
            default: w_result = '0;
        endcase
    end

    // r_active keeps mem_req low while reset is held, without any path from mem_ready.
    assign w_in_mem  = (r_state == S_MEM);
    assign mem_req   = r_active && ((r_state == S_FETCH) || w_in_mem);
    assign mem_we    = w_in_mem && is_store;
    assign mem_addr  = w_in_mem ? r_alu_out : r_pc;
    assign mem_wdata = r_b;
    assign w_xfer    = mem_req && mem_ready;
    assign Instr     = r_instr;
    assign PC        = r_pc;
    assign state     = r_state;

    always_comb begin
        w_state_nxt = r_state;
        instr_done  = 1'b0;
        case (r_state)
            S_FETCH:   if (w_xfer) w_state_nxt = S_DECODE;
            S_DECODE:  w_state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                if (is_branch) begin
                    instr_done  = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (is_jump) begin
                    w_state_nxt = S_WB;
                end else if (is_load || is_store) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (w_xfer) begin
                    if (is_store) begin
                        instr_done  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                instr_done  = 1'b1;
                w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active   <= 1'b0;
            r_pc       <= RESET_PC;
            r_old_pc   <= '0;
            r_instr    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_alu_out  <= '0;
            r_mem_data <= '0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                S_FETCH: if (w_xfer) begin
                    r_instr  <= mem_rdata[31:0];
                    r_old_pc <= r_pc;
                    r_pc     <= r_pc + XLEN'(4);
                end
                S_DECODE: begin
                    r_a       <= w_rs1_val;
                    r_b       <= w_rs2_val;
                    r_alu_out <= r_old_pc + w_imm_ext;
                end
                // Branches keep the DECODE-computed target in r_alu_out.
                S_EXECUTE: begin
                    if (is_branch) begin
                        if (w_taken) r_pc <= r_alu_out;
                    end else if (is_jump) begin
                        r_pc <= r_alu_out;
                    end else begin
                        r_alu_out <= w_alu;
                    end
                end
                S_MEM: if (w_xfer && is_load) r_mem_data <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Register file is deliberately not reset; x0 is never written.
    always_ff @(posedge clk) begin
        if ((r_state == S_WB) && write_enable_rd && (w_rd != '0))
            r_rf[w_rd] <= w_result;
    end
endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: small program in a word memory, an opcode decoder model,
// and immediate-assert checks on latency, PC, memory traffic and register contents.
module tb_datapath_mc;
    import datapath_mc_pkg::*;

    logic        clk, reset, mem_ready;
    logic        mem_req, mem_we, instr_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, Instr, PC;
    logic [2:0]  state;

    instr_type_e t_type;
    logic [3:0]  t_alu;
    logic [1:0]  t_res;
    logic        t_alusrc, t_we, t_ld, t_st, t_br, t_inv, t_jmp;

    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] st_addr, st_data;
    logic        st_we;

    datapath_mc #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .instr_type_enum_inst(t_type),
        .ALUControl(t_alu), .ALUSrc(t_alusrc), .ResultSrc(t_res),
        .write_enable_rd(t_we), .is_load(t_ld), .is_store(t_st),
        .is_branch(t_br), .branch_invert(t_inv), .is_jump(t_jmp),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .Instr(Instr), .PC(PC),
        .state(state), .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 4'd1 : 4'd0;
            3'd1:    return 4'd6;
            3'd2:    return 4'd5;
            3'd4:    return 4'd4;
            3'd5:    return 4'd7;
            3'd6:    return 4'd3;
            3'd7:    return 4'd2;
            default: return 4'd15;
        endcase
    endfunction

    // External decoder model: follows Instr combinationally.
    always_comb begin
        t_type = IMM_R; t_alu = 4'd0; t_alusrc = 1'b0; t_res = 2'd0; t_we = 1'b0;
        t_ld = 1'b0; t_st = 1'b0; t_br = 1'b0; t_inv = 1'b0; t_jmp = 1'b0;
        case (Instr[6:0])
            7'h13: begin t_type = IMM_I; t_alusrc = 1'b1; t_alu = alu_of(Instr[14:12], 1'b0); t_we = 1'b1; end
            7'h33: begin t_type = IMM_R; t_alu = alu_of(Instr[14:12], Instr[30]); t_we = 1'b1; end
            7'h03: begin t_type = IMM_I; t_alusrc = 1'b1; t_ld = 1'b1; t_res = 2'd1; t_we = 1'b1; end
            7'h23: begin t_type = IMM_S; t_alusrc = 1'b1; t_st = 1'b1; end
            7'h63: begin t_type = IMM_B; t_alu = 4'd1; t_br = 1'b1; t_inv = Instr[12]; end
            7'h6F: begin t_type = IMM_J; t_jmp = 1'b1; t_res = 2'd2; t_we = 1'b1; end
            default: ;
        endcase
    end

    function automatic logic [31:0] f_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] f_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] f_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] f_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting at a FETCH negedge; fetch is stalled for 'stall' cycles.
    task automatic run_instr(input int stall, output int cyc, output int nfetch, output logic hold_ok);
        logic [31:0] a0;
        cyc = -1; nfetch = 0; hold_ok = 1'b1; a0 = '0;
        for (int i = 1; i <= 40; i++) begin
            mem_ready = (i <= stall) ? 1'b0 : 1'b1;
            #1;
            if (i == 1) a0 = mem_addr;
            if (state == 3'd0 && (mem_req !== 1'b1 || mem_addr !== a0)) hold_ok = 1'b0;
            if (state == 3'd0 && mem_req && mem_ready) nfetch++;
            if (mem_req && mem_we && mem_ready) begin
                mem[mem_addr[9:2]] = mem_wdata;
                st_we = mem_we; st_addr = mem_addr; st_data = mem_wdata;
            end
            if (instr_done === 1'b1) begin
                cyc = i;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        int   cyc, nf;
        logic hok;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[0]  = 32'h00500093;                      // addi x1,x0,5
        mem[1]  = f_i(12'h100, 5'd0, 3'd0, 5'd2, 7'h13);
        mem[2]  = f_i(12'h37A, 5'd0, 3'd0, 5'd1, 7'h13);
        mem[3]  = f_i(12'd11,  5'd1, 3'd1, 5'd1, 7'h13); // slli x1,x1,11
        mem[4]  = f_i(12'h5B7, 5'd1, 3'd6, 5'd1, 7'h13); // ori
        mem[5]  = f_i(12'd11,  5'd1, 3'd1, 5'd1, 7'h13);
        mem[6]  = f_i(12'h6EF, 5'd1, 3'd6, 5'd1, 7'h13);
        mem[7]  = f_s(12'd8, 5'd1, 5'd2);                // sw x1,8(x2)
        mem[8]  = f_b(13'h1FF8, 5'd0, 5'd0, 3'd0);       // beq x0,x0,-8
        mem[9]  = f_i(12'd8, 5'd2, 3'd2, 5'd3, 7'h03);   // lw x3,8(x2)
        mem[10] = f_j(21'd24, 5'd0);                     // jal x0,+24
        mem[16] = f_j(21'd16, 5'd1);                     // jal x1,+16 at 0x40
        mem[20] = f_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13);   // addi x0,x0,7
        mem[21] = f_i(12'd3, 5'd0, 3'd0, 5'd5, 7'h13);   // addi x5,x0,3
        mem[22] = f_r(7'h20, 5'd2, 5'd5, 3'd0, 5'd6);    // sub x6,x5,x2
        mem[23] = f_r(7'h00, 5'd5, 5'd6, 3'd2, 5'd7);    // slt x7,x6,x5
        mem[24] = f_r(7'h00, 5'd5, 5'd3, 3'd5, 5'd8);    // srl x8,x3,x5
        mem[25] = f_r(7'h00, 5'd1, 5'd3, 3'd4, 5'd9);    // xor x9,x3,x1
        mem[26] = f_r(7'h00, 5'd6, 5'd3, 3'd7, 5'd10);   // and x10,x3,x6
        mem[27] = f_i(12'd8, 5'd2, 3'd2, 5'd5, 7'h03);   // lw x5,8(x2)
        st_we = 1'b0; st_addr = '0; st_data = '0;

        reset = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pc", PC, 32'h0);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_done", {31'd0, instr_done}, 32'd0);
        check("rst_instr", Instr, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);

        run_instr(0, cyc, nf, hok);
        check("addi_cyc", 32'(cyc), 32'd4);
        check("addi_x1", dut.r_rf[1], 32'd5);
        check("addi_pc", PC, 32'h4);

        run_instr(3, cyc, nf, hok);
        check("stall_cyc", 32'(cyc), 32'd7);
        check("stall_nfetch", 32'(nf), 32'd1);
        check("stall_hold", {31'd0, hok}, 32'd1);
        check("stall_x2", dut.r_rf[2], 32'h100);

        repeat (5) run_instr(0, cyc, nf, hok);
        check("build_x1", dut.r_rf[1], 32'hDEADBEEF);
        check("build_pc", PC, 32'h1C);

        run_instr(0, cyc, nf, hok);
        check("sw_cyc", 32'(cyc), 32'd4);
        check("sw_we", {31'd0, st_we}, 32'd1);
        check("sw_addr", st_addr, 32'h108);
        check("sw_wdata", st_data, 32'hDEADBEEF);

        run_instr(0, cyc, nf, hok);
        check("beq_cyc", 32'(cyc), 32'd3);
        check("beq_pc", PC, 32'h18);
        mem[8] = f_b(13'h1FF8, 5'd0, 5'd0, 3'd1);        // bne x0,x0,-8
        repeat (2) run_instr(0, cyc, nf, hok);
        run_instr(0, cyc, nf, hok);
        check("bne_cyc", 32'(cyc), 32'd3);
        check("bne_pc", PC, 32'h24);

        run_instr(0, cyc, nf, hok);
        check("lw_cyc", 32'(cyc), 32'd5);
        check("lw_x3", dut.r_rf[3], 32'hDEADBEEF);

        run_instr(0, cyc, nf, hok);
        check("jal0_pc", PC, 32'h40);
        run_instr(0, cyc, nf, hok);
        check("jal_cyc", 32'(cyc), 32'd4);
        check("jal_pc", PC, 32'h50);
        check("jal_x1", dut.r_rf[1], 32'h44);

        repeat (2) run_instr(0, cyc, nf, hok);
        check("x0_read", dut.r_rf[5], 32'd3);
        run_instr(0, cyc, nf, hok);
        check("sub_x6", dut.r_rf[6], 32'hFFFFFF03);
        run_instr(0, cyc, nf, hok);
        check("slt_x7", dut.r_rf[7], 32'd1);
        run_instr(0, cyc, nf, hok);
        check("srl_x8", dut.r_rf[8], 32'h1BD5B7DD);
        run_instr(0, cyc, nf, hok);
        check("xor_x9", dut.r_rf[9], 32'hDEADBEAB);
        run_instr(0, cyc, nf, hok);
        check("and_x10", dut.r_rf[10], 32'hDEADBE03);

        // lw x5 with reset asserted while MEM is stalled
        mem_ready = 1'b1;
        for (int i = 0; i < 10 && state != 3'd3; i++) @(negedge clk);
        check("mid_state_mem", {29'd0, state}, 32'd3);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_state", {29'd0, state}, 32'd0);
        check("abort_pc", PC, 32'h0);
        check("abort_req", {31'd0, mem_req}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("abort_x5", dut.r_rf[5], 32'd3);
        @(negedge clk);
        run_instr(0, cyc, nf, hok);
        check("rerun_cyc", 32'(cyc), 32'd4);
        check("rerun_pc", PC, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
